// File: rtl/uart_rx.sv
// 16550-style serial receiver on a 16x baud_pulse timebase: start-bit
// validation, 5-8 data bits, optional parity, one stop bit, one-clk push.
module uart_rx #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       baud_pulse,
   input  logic       rx,
   input  logic       pen,
   input  logic       eps,
   input  logic       sticky_parity,
   input  logic [1:0] wls,
   output logic [7:0] dout,
   output logic       push,
   output logic       pe,
   output logic       fe,
   output logic       bi,
   output logic       rx_busy
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      PARITY    = 3'd3,
      STOP      = 3'd4,
      WAIT_HIGH = 3'd5
   } state_t;

   state_t                 state, state_nxt;
   logic [SYNC_STAGES-1:0] sync;
   logic                   rxd;
   logic [3:0]             count, count_nxt;
   logic [2:0]             bitcnt, bitcnt_nxt;
   logic [7:0]             sreg, sreg_nxt;
   logic                   acc, acc_nxt;
   logic                   perr, perr_nxt;
   logic                   pbit, pbit_nxt;
   logic [7:0]             dout_nxt;
   logic                   push_nxt, pe_nxt, fe_nxt, bi_nxt;
   logic                   exp_par;
   logic [7:0]             aligned;

   // Synchronizer runs every clk; it resets to the idle (mark) level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync <= '1;
      else     sync <= {sync[SYNC_STAGES-2:0], rx};
   end

   assign rxd = sync[SYNC_STAGES-1];

   always_comb begin
      exp_par = 1'b0;
      case ({sticky_parity, eps})
         2'b00: exp_par = ~acc;
         2'b01: exp_par = acc;
         2'b10: exp_par = 1'b1;
         2'b11: exp_par = 1'b0;
         default: exp_par = 1'b0;
      endcase
   end

   // Bits enter at the MSB, so short words sit high and need right-aligning.
   assign aligned = sreg >> (2'd3 - wls);

   always_comb begin
      state_nxt  = state;
      count_nxt  = count;
      bitcnt_nxt = bitcnt;
      sreg_nxt   = sreg;
      acc_nxt    = acc;
      perr_nxt   = perr;
      pbit_nxt   = pbit;
      dout_nxt   = dout;
      pe_nxt     = pe;
      fe_nxt     = fe;
      bi_nxt     = bi;
      push_nxt   = 1'b0;
      if (baud_pulse) begin
         case (state)
            IDLE: begin
               if (!rxd) begin
                  state_nxt = START;
                  count_nxt = 4'd7;
               end
            end
            START: begin
               if (count != 4'd0) begin
                  count_nxt = count - 4'd1;
               end else if (rxd) begin
                  state_nxt = IDLE;
               end else begin
                  state_nxt  = DATA;
                  count_nxt  = 4'd15;
                  bitcnt_nxt = {1'b0, wls} + 3'd4;
                  acc_nxt    = 1'b0;
                  perr_nxt   = 1'b0;
                  pbit_nxt   = 1'b0;
               end
            end
            DATA: begin
               if (count != 4'd0) begin
                  count_nxt = count - 4'd1;
               end else begin
                  sreg_nxt  = {rxd, sreg[7:1]};
                  acc_nxt   = acc ^ rxd;
                  count_nxt = 4'd15;
                  if (bitcnt == 3'd0) state_nxt = pen ? PARITY : STOP;
                  else                bitcnt_nxt = bitcnt - 3'd1;
               end
            end
            PARITY: begin
               if (count != 4'd0) begin
                  count_nxt = count - 4'd1;
               end else begin
                  pbit_nxt  = rxd;
                  perr_nxt  = (rxd != exp_par);
                  count_nxt = 4'd15;
                  state_nxt = STOP;
               end
            end
            STOP: begin
               if (count != 4'd0) begin
                  count_nxt = count - 4'd1;
               end else begin
                  dout_nxt  = aligned;
                  pe_nxt    = perr & pen;
                  fe_nxt    = ~rxd;
                  bi_nxt    = (aligned == 8'd0) & (~pbit | ~pen) & ~rxd;
                  push_nxt  = 1'b1;
                  // A low stop bit parks in WAIT_HIGH so a break yields one char.
                  state_nxt = rxd ? IDLE : WAIT_HIGH;
               end
            end
            WAIT_HIGH: begin
               if (rxd) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         count  <= 4'd0;
         bitcnt <= 3'd0;
         sreg   <= 8'd0;
         acc    <= 1'b0;
         perr   <= 1'b0;
         pbit   <= 1'b0;
         dout   <= 8'd0;
         push   <= 1'b0;
         pe     <= 1'b0;
         fe     <= 1'b0;
         bi     <= 1'b0;
      end else begin
         state  <= state_nxt;
         count  <= count_nxt;
         bitcnt <= bitcnt_nxt;
         sreg   <= sreg_nxt;
         acc    <= acc_nxt;
         perr   <= perr_nxt;
         pbit   <= pbit_nxt;
         dout   <= dout_nxt;
         push   <= push_nxt;
         pe     <= pe_nxt;
         fe     <= fe_nxt;
         bi     <= bi_nxt;
      end
   end

   assign rx_busy = (state != IDLE) && (state != WAIT_HIGH);

endmodule
